// File: rtl/mult_sequencer_if.sv
// Core-side bundle for the multi-cycle MULTU/MFHI/MFLO unit.
// The core drives instruction strobes and operands. The unit returns the
// stall/busy/done status and the architectural HI/LO registers.
interface mult_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mfhi;
  logic             mflo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, opa, opb, mfhi, mflo,
    input  stall, busy, done, hi, lo, result
  );

  modport slave (
    input  start, opa, opb, mfhi, mflo,
    output stall, busy, done, hi, lo, result
  );
endinterface

// File: rtl/mult_sequencer.sv
// Iterative unsigned shift-add multiplier with architectural HI/LO registers.
// Each RUN cycle retires BITS_PER_CYCLE multiplier bits. HI/LO are written
// only at commit, and the core is stalled while an unfinished product
// would be read or disturbed.
module mult_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            reset,
  mult_sequencer_if.slave bus
);
  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = WIDTH + BITS_PER_CYCLE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [SW-1:0]      ext_m;
  logic [SW-1:0]      addend;
  logic [SW-1:0]      sum;

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: one shift-add step per RUN cycle, commit on the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    // M * digit is built from shifted copies of M, one per set digit bit.
    ext_m  = {{BITS_PER_CYCLE{1'b0}}, m_q};
    addend = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (p_q[k]) addend = addend + (ext_m << k);
    end
    sum = {{BITS_PER_CYCLE{1'b0}}, p_q[2*WIDTH-1:WIDTH]} + addend;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.opb;
          p_d     = {{WIDTH{1'b0}}, bus.opa};
          cnt_d   = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        // {carry, P_hi, P_lo} >> BITS_PER_CYCLE, keeping the carry bits.
        p_d   = {sum, p_q[WIDTH-1:BITS_PER_CYCLE]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = p_d[2*WIDTH-1:WIDTH];
          lo_d    = p_d[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status and read-back outputs to the core.
  always_comb begin
    bus.busy   = (state_q == RUN);
    bus.stall  = bus.busy & (bus.start | bus.mfhi | bus.mflo);
    bus.done   = done_q;
    bus.hi     = hi_q;
    bus.lo     = lo_q;
    bus.result = bus.mfhi ? hi_q : lo_q;
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: one instance with 1 bit per cycle
// and one with 4 bits per cycle. Expected values come from 64-bit products.
module tb_mult_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mult_sequencer_if #(.WIDTH(W)) b1 ();
  mult_sequencer_if #(.WIDTH(W)) b4 ();

  mult_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mult_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full MULTU on the 1-bit instance: busy for 32 cycles, HI/LO held, then commit.
  task automatic run1(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    exp = ref_prod(a, b);
    old_hi = b1.hi;
    old_lo = b1.lo;
    b1.opa = a; b1.opb = b; b1.start = 1'b1;
    step();
    b1.start = 1'b0; b1.opa = $urandom; b1.opb = $urandom;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (b1.busy !== 1'b1 || b1.done !== 1'b0 || b1.hi !== old_hi || b1.lo !== old_lo) begin
        errors++;
        $display("FAIL %s run%0d: busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
                 tag, i, b1.busy, b1.done, b1.hi, b1.lo, old_hi, old_lo);
      end
      step();
    end
    checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b1 || b1.hi !== exp[63:32] || b1.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s commit: busy=%b done=%b hi=%h lo=%h, required busy=0 done=1 hi=%h lo=%h",
               tag, b1.busy, b1.done, b1.hi, b1.lo, exp[63:32], exp[31:0]);
    end
    step();
    checks++;
    if (b1.done !== 1'b0 || b1.hi !== exp[63:32] || b1.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s after_done: done=%b hi=%h lo=%h, required done=0 hi=%h lo=%h",
               tag, b1.done, b1.hi, b1.lo, exp[63:32], exp[31:0]);
    end
  endtask

  // Full MULTU on the 4-bit instance: busy for 8 cycles.
  task automatic run4(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    exp = ref_prod(a, b);
    b4.opa = a; b4.opb = b; b4.start = 1'b1;
    step();
    b4.start = 1'b0; b4.opa = $urandom; b4.opb = $urandom;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b4.busy !== 1'b1 || b4.done !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d: busy=%b done=%b, required busy=1 done=0", tag, i, b4.busy, b4.done);
      end
      step();
    end
    checks++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b1 || b4.hi !== exp[63:32] || b4.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s commit: busy=%b done=%b hi=%h lo=%h, required busy=0 done=1 hi=%h lo=%h",
               tag, b4.busy, b4.done, b4.hi, b4.lo, exp[63:32], exp[31:0]);
    end
    step();
  endtask

  task automatic test_power_on();
    b1.start = 1'b0; b1.opa = '0; b1.opb = '0; b1.mfhi = 1'b0; b1.mflo = 1'b0;
    b4.start = 1'b0; b4.opa = '0; b4.opb = '0; b4.mfhi = 1'b0; b4.mflo = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b1.hi !== 32'h0 || b1.lo !== 32'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.stall !== 1'b0) begin
      errors++;
      $display("FAIL power_on: hi=%h lo=%h busy=%b done=%b stall=%b, required all zero",
               b1.hi, b1.lo, b1.busy, b1.done, b1.stall);
    end
    #20 reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run1(32'd3, 32'd5, "basic_3x5");
  endtask

  task automatic test_max();
    run1(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    checks++;
    if (b1.hi !== 32'hFFFF_FFFE || b1.lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL max_const: hi=%h lo=%h, required hi=fffffffe lo=00000001", b1.hi, b1.lo);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) run1($urandom, $urandom, "random");
    run1(32'h0, $urandom, "zero_a");
    run1($urandom, 32'h1, "one_b");
  endtask

  // Asynchronous reset in the middle of a run, sampled between clock edges.
  task automatic test_reset();
    b1.opa = 32'h1234_5678; b1.opb = 32'h9ABC_DEF0; b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    repeat (5) step();
    b1.mflo = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b1.hi !== 32'h0 || b1.lo !== 32'h0 || b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: hi=%h lo=%h busy=%b done=%b stall=%b, required all zero",
               b1.hi, b1.lo, b1.busy, b1.done, b1.stall);
    end
    b1.mflo = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  // MFHI issued during a MULTU stalls until commit, then reads the new HI.
  task automatic test_stall();
    int n;
    run1(32'd3, 32'd5, "stall_pre");
    b1.opa = 32'hFFFF_FFFF; b1.opb = 32'hFFFF_FFFF; b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    step();
    b1.mfhi = 1'b1;
    #1;
    n = 0;
    while (b1.busy === 1'b1 && n < 40) begin
      checks++;
      if (b1.stall !== 1'b1 || b1.hi !== 32'h0 || b1.result !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold%0d: stall=%b hi=%h result=%h, required stall=1 hi=0 result=0",
                 n, b1.stall, b1.hi, b1.result);
      end
      n++;
      step();
    end
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL stall_len: stalled %0d cycles, required 31", n);
    end
    checks++;
    if (b1.stall !== 1'b0 || b1.result !== 32'hFFFF_FFFE || b1.done !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: stall=%b result=%h done=%b, required stall=0 result=fffffffe done=1",
               b1.stall, b1.result, b1.done);
    end
    b1.mfhi = 1'b0;
    step();
  endtask

  // Read-back mux: MFLO, MFHI, and both at once (HI wins).
  task automatic test_readback();
    b1.mflo = 1'b1; #1;
    checks++;
    if (b1.result !== 32'h0000_0001) begin
      errors++; $display("FAIL mflo: result=%h, required 00000001", b1.result);
    end
    b1.mfhi = 1'b1; #1;
    checks++;
    if (b1.result !== 32'hFFFF_FFFE || b1.stall !== 1'b0) begin
      errors++; $display("FAIL mfhi_mflo: result=%h stall=%b, required fffffffe stall=0", b1.result, b1.stall);
    end
    b1.mflo = 1'b0; b1.mfhi = 1'b0;
    step();
  endtask

  // Start together with MFHI while idle: start is taken, result shows old HI.
  task automatic test_idle_start_mfhi();
    b1.opa = 32'd2; b1.opb = 32'd3; b1.start = 1'b1; b1.mfhi = 1'b1;
    #1;
    checks++;
    if (b1.stall !== 1'b0 || b1.result !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL idle_start_mfhi: stall=%b result=%h, required stall=0 result=fffffffe", b1.stall, b1.result);
    end
    step();
    b1.start = 1'b0; b1.mfhi = 1'b0;
    checks++;
    if (b1.busy !== 1'b1) begin
      errors++; $display("FAIL idle_start_taken: busy=%b, required 1", b1.busy);
    end
    repeat (32) step();
    checks++;
    if (b1.done !== 1'b1 || b1.hi !== 32'h0 || b1.lo !== 32'd6) begin
      errors++; $display("FAIL idle_start_commit: done=%b hi=%h lo=%h, required done=1 hi=0 lo=6", b1.done, b1.hi, b1.lo);
    end
    step();
  endtask

  // Reset at RUN cycle 10 of 7*9: no done pulse, then a fresh MULTU works.
  task automatic test_abort();
    int seen_done;
    b1.opa = 32'd7; b1.opb = 32'd9; b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    repeat (10) step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (b1.busy !== 1'b0 || b1.hi !== 32'h0 || b1.lo !== 32'h0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b hi=%h lo=%h done=%b, required busy=0 hi=0 lo=0 done=0",
               b1.busy, b1.hi, b1.lo, b1.done);
    end
    step();
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (b1.done === 1'b1 || b1.busy === 1'b1) seen_done++;
      step();
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL abort_quiet: %0d cycles with done/busy, required 0", seen_done);
    end
    run1(32'd7, 32'd9, "after_abort");
  endtask

  // 4 bits per cycle: second start held during busy is stalled, then taken on the done cycle.
  task automatic test_back_to_back();
    logic [31:0] a2, b2;
    logic [63:0] e2;
    a2 = $urandom; b2 = $urandom;
    e2 = ref_prod(a2, b2);
    b4.opa = 32'h8000_0000; b4.opb = 32'd2; b4.start = 1'b1;
    step();
    b4.opa = a2; b4.opb = b2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (b4.busy !== 1'b1 || b4.stall !== 1'b1 || b4.done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy%0d: busy=%b stall=%b done=%b, required busy=1 stall=1 done=0",
                 i, b4.busy, b4.stall, b4.done);
      end
      step();
    end
    checks++;
    if (b4.busy !== 1'b0 || b4.stall !== 1'b0 || b4.done !== 1'b1 || b4.hi !== 32'h1 || b4.lo !== 32'h0) begin
      errors++;
      $display("FAIL b2b_first: busy=%b stall=%b done=%b hi=%h lo=%h, required 0 0 1 hi=00000001 lo=0",
               b4.busy, b4.stall, b4.done, b4.hi, b4.lo);
    end
    step();
    b4.start = 1'b0;
    checks++;
    if (b4.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: busy=%b, required 1", b4.busy);
    end
    repeat (8) step();
    checks++;
    if (b4.done !== 1'b1 || b4.hi !== e2[63:32] || b4.lo !== e2[31:0]) begin
      errors++;
      $display("FAIL b2b_second: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
               b4.done, b4.hi, b4.lo, e2[63:32], e2[31:0]);
    end
    step();
  endtask

  task automatic test_bpc4_random();
    run4(32'hFFFF_FFFF, 32'hFFFF_FFFF, "bpc4_max");
    for (int i = 0; i < 4; i++) run4($urandom, $urandom, "bpc4_random");
  endtask

  initial begin
    test_power_on();
    test_basic();
    test_max();
    test_random();
    test_reset();
    test_stall();
    test_readback();
    test_idle_start_mfhi();
    test_abort();
    test_back_to_back();
    test_bpc4_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
